// File: rtl/playfield_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : playfield_renderer_pkg
// Brief   : Screen geometry, colour constants and renderer state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package playfield_renderer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_RED   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_WALL   = 3'd3,
        S_SPRITE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/playfield_renderer_xy_scan_counter.sv
`default_nettype none
// ============================================================================
// Module  : xy_scan_counter
// Brief   : Nested column/row counter; the row (y) is the fast index and the
//           column (x) advances when the row wraps. Exposes next-cycle values.
// Rev     : 1.0  initial release
// ============================================================================
module xy_scan_counter #(
    parameter int X_CNT = 2,
    parameter int Y_CNT = 2,
    parameter int XW    = (X_CNT > 1) ? $clog2(X_CNT) : 1,
    parameter int YW    = (Y_CNT > 1) ? $clog2(Y_CNT) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [XW-1:0] o_x_nxt,
    output logic [YW-1:0] o_y_nxt,
    output logic          o_last_x,
    output logic          o_last_y
);

    localparam logic [XW-1:0] c_x_max = XW'(X_CNT - 1);
    localparam logic [YW-1:0] c_y_max = YW'(Y_CNT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (i_clr) begin
            w_x_nxt = '0;
            w_y_nxt = '0;
        end else if (i_en) begin
            if (r_y == c_y_max) begin
                w_y_nxt = '0;
                w_x_nxt = (r_x == c_x_max) ? '0 : r_x + 1'b1;
            end else begin
                w_y_nxt = r_y + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end
    end

    assign o_x_nxt  = w_x_nxt;
    assign o_y_nxt  = w_y_nxt;
    assign o_last_x = (r_x == c_x_max);
    assign o_last_y = (r_y == c_y_max);

endmodule
`default_nettype wire

// File: rtl/playfield_renderer.sv
`default_nettype none
// ============================================================================
// Module  : playfield_renderer
// Brief   : Renders the wall bitmap column by column, then overlays the player
//           sprite, through the vga_adapter plot interface.
//           Optional: PLAYFIELD_SPRITE_CLIP_EN suppresses off-field sprite pixels.
// Rev     : 1.0  initial release
// ============================================================================
module playfield_renderer
    import playfield_renderer_pkg::*;
#(
    parameter int         FIELD_W     = 120,
    parameter int         FIELD_H     = 100,
    parameter int         ORG_X       = 20,
    parameter int         ORG_Y       = 10,
    parameter int         SPR_W       = 4,
    parameter int         SPR_H       = 6,
    parameter logic [2:0] WALL_COLOUR = COL_WHITE,
    parameter logic [2:0] BG_COLOUR   = COL_BLACK,
    parameter logic [2:0] SPR_COLOUR  = COL_RED
) (
    input  logic                                               clk,
    input  logic                                               resetn,
    input  logic                                               start,
    output logic                                               busy,
    output logic                                               done,
    output logic                                               col_rd_en,
    output logic [((FIELD_W > 1) ? $clog2(FIELD_W) : 1)-1:0]   col_addr,
    input  logic [FIELD_H-1:0]                                 col_data,
    input  logic [6:0]                                         spr_x,
    input  logic [6:0]                                         spr_y,
    output logic                                               plot,
    output logic [7:0]                                         plot_x,
    output logic [6:0]                                         plot_y,
    output logic [2:0]                                         plot_colour
);

    localparam int c_col_w = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;
    localparam int c_row_w = (FIELD_H > 1) ? $clog2(FIELD_H) : 1;
    localparam int c_i_w   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int c_j_w   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [8:0] c_org_x = 9'(ORG_X);
    localparam logic [8:0] c_org_y = 9'(ORG_Y);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [FIELD_H-1:0]   r_col_word;
    logic [6:0]           r_spr_x;
    logic [6:0]           r_spr_y;

    logic                 r_busy;
    logic                 r_done;
    logic                 r_col_rd_en;
    logic [c_col_w-1:0]   r_col_addr;
    logic                 r_plot;
    logic [7:0]           r_plot_x;
    logic [6:0]           r_plot_y;
    logic [2:0]           r_plot_colour;

    logic                 w_accept;
    logic [c_col_w-1:0]   w_col_nxt;
    logic [c_row_w-1:0]   w_row_nxt;
    logic                 w_wall_last_x;
    logic                 w_wall_last_y;
    logic [c_i_w-1:0]     w_i_nxt;
    logic [c_j_w-1:0]     w_j_nxt;
    logic                 w_spr_last_x;
    logic                 w_spr_last_y;
    logic [FIELD_H-1:0]   w_word;
    logic                 w_spr_vis;

    assign w_accept = (r_state == S_IDLE) && start;

    xy_scan_counter #(
        .X_CNT (FIELD_W),
        .Y_CNT (FIELD_H),
        .XW    (c_col_w),
        .YW    (c_row_w)
    ) u_wall_scan (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (w_accept),
        .i_en     (r_state == S_WALL),
        .o_x_nxt  (w_col_nxt),
        .o_y_nxt  (w_row_nxt),
        .o_last_x (w_wall_last_x),
        .o_last_y (w_wall_last_y)
    );

    xy_scan_counter #(
        .X_CNT (SPR_W),
        .Y_CNT (SPR_H),
        .XW    (c_i_w),
        .YW    (c_j_w)
    ) u_spr_scan (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (w_accept),
        .i_en     (r_state == S_SPRITE),
        .o_x_nxt  (w_i_nxt),
        .o_y_nxt  (w_j_nxt),
        .o_last_x (w_spr_last_x),
        .o_last_y (w_spr_last_y)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_WALL;
            S_WALL:   if (w_wall_last_y) w_state_nxt = w_wall_last_x ? S_SPRITE : S_FETCH;
            S_SPRITE: if (w_spr_last_x && w_spr_last_y) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // The first wall pixel of a column is emitted while the word is still on the bus.
    assign w_word = (r_state == S_LOAD) ? col_data : r_col_word;

`ifdef PLAYFIELD_SPRITE_CLIP_EN
    assign w_spr_vis = ((9'(r_spr_x) + 9'(w_i_nxt)) < 9'(FIELD_W)) &&
                       ((9'(r_spr_y) + 9'(w_j_nxt)) < 9'(FIELD_H));
`else
    assign w_spr_vis = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col_word <= '0;
            r_spr_x    <= '0;
            r_spr_y    <= '0;
        end else begin
            if (w_accept) begin
                r_spr_x <= spr_x;
                r_spr_y <= spr_y;
            end
            if (r_state == S_LOAD) begin
                r_col_word <= col_data;
            end
        end
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_col_rd_en   <= 1'b0;
            r_col_addr    <= '0;
            r_plot        <= 1'b0;
            r_plot_x      <= '0;
            r_plot_y      <= '0;
            r_plot_colour <= BG_COLOUR;
        end else begin
            r_busy      <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_LOAD) ||
                           (w_state_nxt == S_WALL)  || (w_state_nxt == S_SPRITE);
            r_done      <= (w_state_nxt == S_DONE);
            r_col_rd_en <= (w_state_nxt == S_FETCH);
            r_plot      <= 1'b0;
            if (w_state_nxt == S_FETCH) begin
                r_col_addr <= w_col_nxt;
            end
            if (w_state_nxt == S_WALL) begin
                r_plot        <= 1'b1;
                r_plot_x      <= 8'(c_org_x + 9'(w_col_nxt));
                r_plot_y      <= 7'(c_org_y + 9'(w_row_nxt));
                r_plot_colour <= w_word[w_row_nxt] ? WALL_COLOUR : BG_COLOUR;
            end else if (w_state_nxt == S_SPRITE) begin
                r_plot        <= w_spr_vis;
                r_plot_x      <= 8'(c_org_x + 9'(r_spr_x) + 9'(w_i_nxt));
                r_plot_y      <= 7'(c_org_y + 9'(r_spr_y) + 9'(w_j_nxt));
                r_plot_colour <= SPR_COLOUR;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign col_rd_en   = r_col_rd_en;
    assign col_addr    = r_col_addr;
    assign plot        = r_plot;
    assign plot_x      = r_plot_x;
    assign plot_y      = r_plot_y;
    assign plot_colour = r_plot_colour;

endmodule
`default_nettype wire

// File: tb/tb_playfield_renderer.sv
`default_nettype none
// ============================================================================
// Module  : tb_playfield_renderer
// Brief   : Scoreboard bench for playfield_renderer with default parameters.
// Rev     : 1.0  initial release
// ============================================================================
module tb_playfield_renderer;

    localparam int FW = 120;
    localparam int FH = 100;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          busy;
    logic          done;
    logic          col_rd_en;
    logic [6:0]    col_addr;
    logic [FH-1:0] col_data;
    logic [6:0]    spr_x;
    logic [6:0]    spr_y;
    logic          plot;
    logic [7:0]    plot_x;
    logic [6:0]    plot_y;
    logic [2:0]    plot_colour;

    logic [FH-1:0] mem [0:FW-1];
    logic [17:0]   exp_q [$];
    logic [17:0]   mon_e;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int done_count = 0;
    int done_cyc   = 0;

    playfield_renderer u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .col_rd_en   (col_rd_en),
        .col_addr    (col_addr),
        .col_data    (col_data),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .plot        (plot),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Column memory: data valid only in the cycle after the read strobe.
    always @(posedge clk) begin
        col_data <= col_rd_en ? mem[col_addr] : {25{4'b1010}};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected pixel per plot strobe, records done pulses.
    always @(posedge clk) begin
        #1;
        if (plot) begin
            if (exp_q.size() == 0) begin
                check("plot_unexpected", {31'b0, plot}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("plot_pixel", {14'b0, plot_x, plot_y, plot_colour}, {14'b0, mon_e});
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    function automatic void push_wall();
        for (int c = 0; c < FW; c++) begin
            for (int r = 0; r < FH; r++) begin
                exp_q.push_back({8'(20 + c), 7'(10 + r), (mem[c][r] ? 3'b111 : 3'b000)});
            end
        end
    endfunction

    function automatic void push_sprite(input int sx, input int sy);
        bit vis;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 6; j++) begin
                vis = 1'b1;
`ifdef PLAYFIELD_SPRITE_CLIP_EN
                vis = (sx + i < FW) && (sy + j < FH);
`endif
                if (vis) exp_q.push_back({8'(20 + sx + i), 7'(10 + sy + j), 3'b100});
            end
        end
    endfunction

    task automatic run_frame(input logic [6:0] sx, input logic [6:0] sy,
                             input int restart_at, input bit start_on_done);
        int n0;
        int d0;
        push_wall();
        push_sprite(int'(sx), int'(sy));
        @(negedge clk);
        spr_x = sx;
        spr_y = sy;
        start = 1'b1;
        n0 = cyc;
        d0 = done_count;
        @(negedge clk);
        start = 1'b0;
        spr_x = 7'h7f;
        spr_y = 7'h7f;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        if (restart_at > 0) begin
            while (cyc < n0 + restart_at) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 13000 && done_count == d0; k++) @(negedge clk);
        check("done_seen", 32'(done_count - d0), 32'd1);
        check("done_latency", 32'(done_cyc - n0), 32'd12265);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        if (start_on_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (10) @(negedge clk);
        check("idle_after_done", {31'b0, busy}, 32'd0);
        check("single_done", 32'(done_count - d0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_reset_frame();
        int n0;
        int d0;
        push_wall();
        @(negedge clk);
        spr_x = 7'd5;
        spr_y = 7'd5;
        start = 1'b1;
        n0 = cyc;
        d0 = done_count;
        @(negedge clk);
        start = 1'b0;
        while (cyc < n0 + 3000) @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_mid_plot", {31'b0, plot}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_col_addr", {25'b0, col_addr}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_done", 32'(done_count - d0), 32'd0);
        check("rst_idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        spr_x  = '0;
        spr_y  = '0;
        for (int c = 0; c < FW; c++) mem[c] = '0;
        repeat (3) @(negedge clk);
        check("rst_plot", {31'b0, plot}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_col_rd_en", {31'b0, col_rd_en}, 32'd0);
        check("rst_col_addr", {25'b0, col_addr}, 32'd0);
        check("rst_plot_x", {24'b0, plot_x}, 32'd0);
        check("rst_plot_y", {25'b0, plot_y}, 32'd0);
        check("rst_colour", {29'b0, plot_colour}, 32'd0);
        resetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_plot", {31'b0, plot}, 32'd0);
            check("idle_busy", {31'b0, busy}, 32'd0);
            check("idle_done", {31'b0, done}, 32'd0);
        end

        // Column 0 solid wall, sprite at (5,40), stray start at cycle 500.
        mem[0] = '1;
        run_frame(7'd5, 7'd40, 500, 1'b0);

        run_reset_frame();

        // Boundary bits: top/bottom rows and the last column; start coincident with done.
        for (int c = 0; c < FW; c++) mem[c] = '0;
        mem[1]   = {1'b1, 99'b0};
        mem[60]  = {99'b0, 1'b1};
        mem[119] = {25{4'b0101}};
        run_frame(7'd0, 7'd0, 0, 1'b1);

        // Sprite straddling the right field edge.
        run_frame(7'd118, 7'd0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=%0d required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/playfield_renderer.md
Name: playfield_renderer

Overview:
- Parametrised frame renderer feeding the vga_adapter plot interface (160x120, 3-bit colour).
- On a start pulse, scans a wall bitmap column by column from an external column memory, one column word per fetch, and plots every field pixel as wall or background.
- Then overlays the player sprite at a position latched at start.
- Replaces the flat wide-bus redraw with a start/busy/done handshake and a memory read port.

Parameters:
- FIELD_W, 120, field width in columns.
- FIELD_H, 100, field height in rows; also the column word width.
- ORG_X, 20, screen x of field column 0.
- ORG_Y, 10, screen y of field row 0.
- SPR_W, 4, sprite width in pixels.
- SPR_H, 6, sprite height in pixels.
- WALL_COLOUR, 3'b111, colour for set bitmap bits.
- BG_COLOUR, 3'b000, colour for clear bitmap bits.
- SPR_COLOUR, 3'b100, sprite colour.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low; clock clk
- start  in  1  single-cycle request to render one frame
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last sprite pixel
- col_rd_en  out  1  column memory read strobe
- col_addr  out  $clog2(FIELD_W)  column index being read
- col_data  in  FIELD_H  column word, valid exactly 1 cycle after col_rd_en; bit j is row j
- spr_x  in  7  sprite left column, field-relative
- spr_y  in  7  sprite top row, field-relative
- plot  out  1  pixel write strobe to vga_adapter
- plot_x  out  8  screen x
- plot_y  out  7  screen y
- plot_colour  out  3  pixel colour

Behaviour:
- Reset values: busy=0, done=0, plot=0, col_rd_en=0, col_addr=0, plot_x=0, plot_y=0, plot_colour=BG_COLOUR. State returns to S_IDLE.
- Reset mid-frame: the frame is abandoned. No done pulse is generated.
- FSM states and transitions:
  - S_IDLE: waits for start. start is sampled only here and is ignored while busy. On start, latch spr_x/spr_y, set col=0, go to S_FETCH.
  - S_FETCH: col_rd_en=1, col_addr=col, go to S_LOAD.
  - S_LOAD: capture col_data into the column register, set row=0, go to S_WALL.
  - S_WALL: one pixel per cycle. plot=1, plot_x=ORG_X+col, plot_y=ORG_Y+row, plot_colour=WALL_COLOUR if bit[row] else BG_COLOUR.
    - At row=FIELD_H-1: if col=FIELD_W-1, go to S_SPRITE with i=j=0; else col+1, go to S_FETCH.
  - S_SPRITE: one pixel per cycle. plot_x=ORG_X+spr_x+i, plot_y=ORG_Y+spr_y+j, colour SPR_COLOUR.
    - Scan is column-major: j runs 0..SPR_H-1, then i increments.
    - After i=SPR_W-1 and j=SPR_H-1, go to S_DONE.
  - S_DONE: done=1 for one cycle, busy drops to 0 in the same cycle, return to S_IDLE.
- Outputs are all registered. The plot/xy/colour triple is coherent in the same cycle.
- plot=0 in S_IDLE, S_FETCH, S_LOAD and S_DONE.
- Frame latency with defaults: 120*(100+2) + 24 = 12264 cycles from the first S_FETCH to the last sprite plot. done follows in the next cycle.
- Width rules:
  - Screen coordinate sums are computed at 9 bits and truncated to 8 (x) / 7 (y).
  - Coordinates that wrap are not corrected; the caller keeps the sprite in range, or enables clipping.
- start asserted in the same cycle as done is ignored. A new frame needs start in S_IDLE.
- Parameter legality: FIELD_W>=1, FIELD_H>=1, SPR_W>=1, SPR_H>=1, ORG_X+FIELD_W<=160, ORG_Y+FIELD_H<=120.

Optional Feature:
- Macro: PLAYFIELD_SPRITE_CLIP_EN.
- Defined: sprite pixels with spr_x+i>=FIELD_W or spr_y+j>=FIELD_H are emitted with plot=0. The cycle is still consumed, so latency is unchanged.
- Undefined: all SPR_W*SPR_H sprite pixels are plotted unconditionally.

Decomposition:
- Shared package holds:
  - screen constants SCREEN_W=160, SCREEN_H=120;
  - colour constants COL_BLACK, COL_WHITE, COL_RED;
  - the renderer state enum (S_IDLE, S_FETCH, S_LOAD, S_WALL, S_SPRITE, S_DONE).
- One sub-module: xy_scan_counter, a parametrised nested column/row counter with enable, clear and a last flag. It is instantiated for both the wall scan and the sprite scan.

Test Plan:
- Reset, then idle 10 cycles -> plot=0, busy=0, done=0 throughout.
- Memory with column 0 = all ones and others zero; start -> first S_WALL pixels are (20,10..109) WALL_COLOUR. Column 1 pixels are (21,y) BG_COLOUR. done arrives exactly 12265 cycles after start.
- spr_x=5, spr_y=40 -> last 24 plots cover x 25..28, y 50..55, colour 3'b100, column-major order.
- start pulsed again at cycle 500 of a frame -> ignored; exactly one done pulse.
- resetn low at cycle 3000 -> plot=0 next cycle, busy=0, no done. A fresh start then renders a full frame.
- PLAYFIELD_SPRITE_CLIP_EN with spr_x=118, spr_y=0 -> only i=0,1 pixels plotted (12 plots). Without the macro, all 24 are plotted.
